// File: rtl/pwm_timebase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_timebase: prescaled PWM period counter with double-buffered config.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_timebase #(
  parameter int bitwidth           = 10,
  parameter int prescaler_bitwidth = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          config_valid,
  output logic                          config_ready,
  input  logic [bitwidth-1:0]           config_period,
  input  logic [bitwidth-1:0]           config_rising,
  input  logic [bitwidth-1:0]           config_falling,
  input  logic [prescaler_bitwidth-1:0] config_prescaler,
  output logic [bitwidth-1:0]           counter,
  output logic [bitwidth-1:0]           tick_number_rising_edge,
  output logic [bitwidth-1:0]           tick_number_falling_edge,
  output logic                          period_start,
  output logic                          update_applied
);

  logic [bitwidth-1:0]           r_counter          = '0;
  logic [prescaler_bitwidth-1:0] r_prescale_count   = '0;
  logic [bitwidth-1:0]           r_active_period    = '1;
  logic [bitwidth-1:0]           r_active_rising    = '0;
  logic [bitwidth-1:0]           r_active_falling   = '0;
  logic [prescaler_bitwidth-1:0] r_active_prescaler = '0;
  logic [bitwidth-1:0]           r_pending_period   = '0;
  logic [bitwidth-1:0]           r_pending_rising   = '0;
  logic [bitwidth-1:0]           r_pending_falling  = '0;
  logic [prescaler_bitwidth-1:0] r_pending_prescaler = '0;
  logic                          r_pending          = 1'b0;
  logic                          r_period_start     = 1'b0;
  logic                          r_update_applied   = 1'b0;

  logic w_tick;
  logic w_wrap;
  logic w_accept;
  logic w_apply;

  assign w_tick   = (r_prescale_count == r_active_prescaler);
  assign w_wrap   = enable && w_tick && (r_counter == r_active_period);
  assign w_accept = config_valid && !r_pending;
  // Only data pending at cycle start may go active; a same-cycle handshake waits.
  assign w_apply  = r_pending && (w_wrap || !enable);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_counter           <= '0;
      r_prescale_count    <= '0;
      r_active_period     <= '1;
      r_active_rising     <= '0;
      r_active_falling    <= '0;
      r_active_prescaler  <= '0;
      r_pending_period    <= '0;
      r_pending_rising    <= '0;
      r_pending_falling   <= '0;
      r_pending_prescaler <= '0;
      r_pending           <= 1'b0;
      r_period_start      <= 1'b0;
      r_update_applied    <= 1'b0;
    end else begin
      r_period_start   <= w_wrap;
      r_update_applied <= w_apply;

      if (!enable) begin
        r_counter        <= '0;
        r_prescale_count <= '0;
      end else if (w_tick) begin
        r_prescale_count <= '0;
        r_counter        <= w_wrap ? '0 : r_counter + 1'b1;
      end else begin
        r_prescale_count <= r_prescale_count + 1'b1;
      end

      if (w_apply) begin
        r_active_period    <= r_pending_period;
        r_active_rising    <= r_pending_rising;
        r_active_falling   <= r_pending_falling;
        r_active_prescaler <= r_pending_prescaler;
        r_pending          <= 1'b0;
      end else if (w_accept) begin
        r_pending_period    <= config_period;
        r_pending_rising    <= config_rising;
        r_pending_falling   <= config_falling;
        r_pending_prescaler <= config_prescaler;
        r_pending           <= 1'b1;
      end
    end
  end

  assign config_ready             = !r_pending;
  assign counter                  = r_counter;
  assign tick_number_rising_edge  = r_active_rising;
  assign tick_number_falling_edge = r_active_falling;
  assign period_start             = r_period_start;
  assign update_applied           = r_update_applied;

endmodule
`default_nettype wire

// File: tb/tb_pwm_timebase.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_timebase: randomized bench against a behavioural timebase model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pwm_timebase;
  localparam int BW = 4;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          config_valid = 1'b0;
  logic          config_ready;
  logic [BW-1:0] config_period = '0;
  logic [BW-1:0] config_rising = '0;
  logic [BW-1:0] config_falling = '0;
  logic [PW-1:0] config_prescaler = '0;
  logic [BW-1:0] counter;
  logic [BW-1:0] tick_number_rising_edge;
  logic [BW-1:0] tick_number_falling_edge;
  logic          period_start;
  logic          update_applied;

  pwm_timebase #(.bitwidth(BW), .prescaler_bitwidth(PW)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .enable                   (enable),
    .config_valid             (config_valid),
    .config_ready             (config_ready),
    .config_period            (config_period),
    .config_rising            (config_rising),
    .config_falling           (config_falling),
    .config_prescaler         (config_prescaler),
    .counter                  (counter),
    .tick_number_rising_edge  (tick_number_rising_edge),
    .tick_number_falling_edge (tick_number_falling_edge),
    .period_start             (period_start),
    .update_applied           (update_applied)
  );

  always #5 clock = ~clock;

  typedef struct {
    int period;
    int rise;
    int fall;
    int presc;
  } cfg_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  cfg_t m_act;
  cfg_t m_pend[$];
  int   m_count;
  int   m_clocks_in_tick;
  int   m_ps;
  int   m_ua;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, written from the observable rules: a tick every
  // (prescaler+1) clocks, the count runs modulo (period+1), config swaps at wrap.
  task automatic model_step();
    bit   had_pending;
    bit   tick;
    bit   wrap;
    cfg_t c;
    if (reset) begin
      m_act = '{period: (1 << BW) - 1, rise: 0, fall: 0, presc: 0};
      m_pend.delete();
      m_count = 0; m_clocks_in_tick = 0; m_ps = 0; m_ua = 0;
      return;
    end
    had_pending = (m_pend.size() != 0);
    tick = enable && (m_clocks_in_tick + 1 == m_act.presc + 1);
    wrap = tick && ((m_count + 1) % (m_act.period + 1) == 0);
    m_ps = wrap;
    if (!enable) begin
      m_count = 0; m_clocks_in_tick = 0;
    end else if (tick) begin
      m_count = (m_count + 1) % (m_act.period + 1);
      m_clocks_in_tick = 0;
    end else begin
      m_clocks_in_tick++;
    end
    m_ua = 0;
    if (had_pending && (wrap || !enable)) begin
      m_act = m_pend.pop_front();
      m_ua = 1;
    end else if (config_valid && !had_pending) begin
      c = '{period: int'(config_period), rise: int'(config_rising),
            fall: int'(config_falling), presc: int'(config_prescaler)};
      m_pend.push_back(c);
    end
  endtask

  task automatic compare_all();
    check("counter", int'(counter), m_count);
    check("rising", int'(tick_number_rising_edge), m_act.rise);
    check("falling", int'(tick_number_falling_edge), m_act.fall);
    check("period_start", int'(period_start), m_ps);
    check("update_applied", int'(update_applied), m_ua);
    check("config_ready", int'(config_ready), (m_pend.size() == 0) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic offer(input int p, input int r, input int f, input int s);
    config_valid     = 1'b1;
    config_period    = BW'(p);
    config_rising    = BW'(r);
    config_falling   = BW'(f);
    config_prescaler = PW'(s);
  endtask

  initial begin
    // Reset state.
    reset = 1'b1; enable = 1'b0;
    cycle();
    check("rst_counter", int'(counter), 0);
    check("rst_ready", int'(config_ready), 1);
    check("rst_falling", int'(tick_number_falling_edge), 0);
    check("rst_pstart", int'(period_start), 0);

    // Full 16-count period with a mid-period config offer at counter=7.
    reset = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cycle();
      check("count_up", int'(counter), i);
      if (i == 7) offer(5, 1, 3, 0);
      else config_valid = 1'b0;
      if (i == 8) check("ready_low", int'(config_ready), 0);
      if (i == 14) check("rise_held", int'(tick_number_rising_edge), 0);
    end
    cycle();
    check("wrap_counter", int'(counter), 0);
    check("wrap_pstart", int'(period_start), 1);
    check("wrap_applied", int'(update_applied), 1);
    check("wrap_rise", int'(tick_number_rising_edge), 1);
    check("wrap_fall", int'(tick_number_falling_edge), 3);
    cycle();
    check("ready_back", int'(config_ready), 1);
    check("count_after", int'(counter), 1);

    // Reset while a configuration is pending.
    offer(9, 2, 7, 1);
    cycle();
    config_valid = 1'b0;
    cycle();
    cycle();
    check("pre_rst_count", int'(counter), 4);
    check("pre_rst_ready", int'(config_ready), 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst2_counter", int'(counter), 0);
    check("rst2_ready", int'(config_ready), 1);
    check("rst2_rise", int'(tick_number_rising_edge), 0);
    for (int i = 0; i < 20; i++) cycle();

    // Randomized operation.
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0)
        offer($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
      else
        config_valid = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
